// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and interrupt controller for the 3-stage RV32 pipeline.
// Drives the writeback mux CSR input and the fetch redirect on trap entry / MRET.
// Optional build macro CSR_COUNTERS_EN adds 64-bit mcycle/minstret and the instr_retired input.
module csr_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [1:0]  csr_op,
    input  logic        csr_wr_en,
    input  logic        is_mret,
    input  logic        timer_irq,
    input  logic        ext_irq,
`ifdef CSR_COUNTERS_EN
    input  logic        instr_retired,
`endif
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic        mstatus_mie, mstatus_mpie;
    logic        mie_mtie, mie_meie;
    logic        mip_mtip, mip_meip;
    logic [31:0] mtvec, mepc, mcause;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;
    logic [63:0] mcycle_inc, minstret_inc;
`endif

    logic [31:0] rdata_raw, wval;
    logic        ext_take, irq, trap, mret, wr;

    // Interrupt / MRET / write qualification; a trap suppresses both MRET and the CSR write
    always_comb begin
        ext_take = mie_meie & mip_meip;
        irq      = mstatus_mie & (ext_take | (mie_mtie & mip_mtip));
        trap     = irq & instr_valid;
        mret     = instr_valid & is_mret & ~trap;
        wr       = instr_valid & csr_wr_en & ~trap & (csr_op != 2'b00);
    end

    // Read mux: pre-write value of the addressed CSR, 0 for unimplemented addresses
    always_comb begin
        rdata_raw = '0;
        case (csr_addr)
            12'h300: rdata_raw = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
            12'h304: rdata_raw = {20'h0, mie_meie, 3'b000, mie_mtie, 7'b0000000};
            12'h344: rdata_raw = {20'h0, mip_meip, 3'b000, mip_mtip, 7'b0000000};
            12'h305: rdata_raw = mtvec;
            12'h341: rdata_raw = mepc;
            12'h342: rdata_raw = mcause;
            12'hF14: rdata_raw = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00: rdata_raw = mcycle[31:0];
            12'hB80: rdata_raw = mcycle[63:32];
            12'hB02: rdata_raw = minstret[31:0];
            12'hB82: rdata_raw = minstret[63:32];
`endif
            default: rdata_raw = '0;
        endcase
    end

    // Write value for CSRRW / CSRRS / CSRRC
    always_comb begin
        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rdata_raw | csr_wdata;
            2'b11:   wval = rdata_raw & ~csr_wdata;
            default: wval = rdata_raw;
        endcase
    end

    // Outputs are forced quiet while reset is held
    always_comb begin
        csr_rdata   = rst ? '0 : rdata_raw;
        redirect    = ~rst & (trap | mret);
        redirect_pc = trap ? mtvec : mepc;
    end

    // CSR state: trap entry has priority; otherwise MRET then the CSR write (write wins on overlap)
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mtvec        <= RESET_MTVEC & ~32'h3;
            mepc         <= '0;
            mcause       <= '0;
        end else begin
            mip_mtip <= timer_irq;
            mip_meip <= ext_irq;
            if (trap) begin
                mepc         <= pc_in & ~32'h3;
                mcause       <= ext_take ? 32'h8000_000B : 32'h8000_0007;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                if (wr) begin
                    case (csr_addr)
                        12'h300: begin
                            mstatus_mie  <= wval[3];
                            mstatus_mpie <= wval[7];
                        end
                        12'h304: begin
                            mie_mtie <= wval[7];
                            mie_meie <= wval[11];
                        end
                        12'h305: mtvec  <= wval & ~32'h3;
                        12'h341: mepc   <= wval & ~32'h3;
                        12'h342: mcause <= wval;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_comb begin
        mcycle_inc   = mcycle + 64'd1;
        minstret_inc = minstret + {63'd0, instr_retired};
    end

    // Counters: free-running increment, a write to one half replaces only that half
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_inc;
            minstret <= minstret_inc;
            if (wr) begin
                case (csr_addr)
                    12'hB00: mcycle[31:0]    <= wval;
                    12'hB80: mcycle[63:32]   <= wval;
                    12'hB02: minstret[31:0]  <= wval;
                    12'hB82: minstret[63:32] <= wval;
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed plus randomized checks of csr_unit against a register-level reference model.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [1:0]  csr_op = '0;
    logic        csr_wr_en = 1'b0;
    logic        is_mret = 1'b0;
    logic        timer_irq = 1'b0;
    logic        ext_irq = 1'b0;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef CSR_COUNTERS_EN
    logic        ret_drv = 1'b0;
    logic        ret_req = 1'b0;
    logic [63:0] m_mcycle = '0, m_minstret = '0;
`endif

    always #5 clk = ~clk;

    csr_unit #(.RESET_MTVEC(32'h100), .HART_ID(32'h5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_op(csr_op),
        .csr_wr_en(csr_wr_en), .is_mret(is_mret), .timer_irq(timer_irq),
        .ext_irq(ext_irq),
`ifdef CSR_COUNTERS_EN
        .instr_retired(ret_drv),
`endif
        .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    int unsigned nvec = 0, nmis = 0;

    // Reference model: architectural CSR values as plain 32-bit words
    logic [31:0] m_mstatus = '0, m_mie = '0, m_mip = '0;
    logic [31:0] m_mtvec = '0, m_mepc = '0, m_mcause = '0;
    logic [31:0] obs_rdata, obs_pc;
    logic        obs_redirect;

    logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342,
                                12'hF14, 12'h7C0, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123};
    logic        r_r, r_v, r_we, r_mr, r_ti, r_ei;
    logic [31:0] r_pc, r_wd;
    logic [11:0] r_a;
    logic [1:0]  r_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h344: return m_mip;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hF14: return 32'h5;
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model
    task automatic cyc(input logic r, input logic v, input logic [31:0] pc, input logic [11:0] a,
                       input logic [31:0] wd, input logic [1:0] op, input logic we,
                       input logic mr, input logic ti, input logic ei);
        logic irq, trap, mret, ext;
        logic [31:0] old, nv;
        @(negedge clk);
        rst = r; instr_valid = v; pc_in = pc; csr_addr = a; csr_wdata = wd;
        csr_op = op; csr_wr_en = we; is_mret = mr; timer_irq = ti; ext_irq = ei;
`ifdef CSR_COUNTERS_EN
        ret_drv = ret_req;
`endif
        #2;
        obs_rdata = csr_rdata; obs_redirect = redirect; obs_pc = redirect_pc;
        ext  = m_mie[11] && m_mip[11];
        irq  = m_mstatus[3] && (ext || (m_mie[7] && m_mip[7]));
        trap = v && irq;
        mret = v && mr && !trap;
        check("rdata", obs_rdata, r ? 32'h0 : mread(a));
        check("redirect", {31'b0, obs_redirect}, {31'b0, !r && (trap || mret)});
        if (!r && (trap || mret))
            check("redirect_pc", obs_pc, trap ? m_mtvec : m_mepc);
        if (r) begin
            m_mstatus = '0; m_mie = '0; m_mip = '0;
            m_mtvec = 32'h100; m_mepc = '0; m_mcause = '0;
`ifdef CSR_COUNTERS_EN
            m_mcycle = '0; m_minstret = '0;
`endif
        end else begin
            old = mread(a);
`ifdef CSR_COUNTERS_EN
            m_mcycle = m_mcycle + 1;
            if (ret_drv) m_minstret = m_minstret + 1;
`endif
            if (trap) begin
                m_mepc    = pc & ~32'h3;
                m_mcause  = ext ? 32'h8000_000B : 32'h8000_0007;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else begin
                if (mret) m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
                if (v && we && op != 2'b00) begin
                    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
                    case (a)
                        12'h300: m_mstatus = nv & 32'h88;
                        12'h304: m_mie     = nv & 32'h880;
                        12'h305: m_mtvec   = nv & ~32'h3;
                        12'h341: m_mepc    = nv & ~32'h3;
                        12'h342: m_mcause  = nv;
`ifdef CSR_COUNTERS_EN
                        12'hB00: m_mcycle[31:0]    = nv;
                        12'hB80: m_mcycle[63:32]   = nv;
                        12'hB02: m_minstret[31:0]  = nv;
                        12'hB82: m_minstret[63:32] = nv;
`endif
                        default: ;
                    endcase
                end
            end
            m_mip = (ti ? 32'h80 : 32'h0) | (ei ? 32'h800 : 32'h0);
        end
    endtask

    task automatic rd(input logic [11:0] a);
        cyc(1'b0, 1'b0, 32'h0, a, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic csrw(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 32'h1000, a, wd, op, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 32'h0, 12'h305, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0, 12'h305, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_rdata", obs_rdata, 32'h0);

        rd(12'h305); check("plan_mtvec_reset", obs_rdata, 32'h100);
        rd(12'h300); check("plan_mstatus_reset", obs_rdata, 32'h0);
        rd(12'h7C0); check("plan_unimpl", obs_rdata, 32'h0);
        rd(12'hF14); check("plan_hartid", obs_rdata, 32'h5);

        csrw(12'h341, 2'b01, 32'h1237); check("plan_csrrw_old", obs_rdata, 32'h0);
        rd(12'h341); check("plan_mepc_aligned", obs_rdata, 32'h1234);
        csrw(12'h304, 2'b10, 32'h880);
        rd(12'h304); check("plan_csrrs", obs_rdata, 32'h880);
        csrw(12'h304, 2'b11, 32'h80);
        rd(12'h304); check("plan_csrrc", obs_rdata, 32'h800);
        csrw(12'h304, 2'b10, 32'h0);
        rd(12'h304); check("plan_set_zero", obs_rdata, 32'h800);

        csrw(12'h305, 2'b01, 32'h200);
        csrw(12'h304, 2'b10, 32'h880);
        csrw(12'h300, 2'b10, 32'h8);
        cyc(1'b0, 1'b1, 32'h40, 12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("plan_irq_latency", {31'b0, obs_redirect}, 32'h0);
        cyc(1'b0, 1'b1, 32'h40, 12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("plan_trap_redirect", {31'b0, obs_redirect}, 32'h1);
        check("plan_trap_pc", obs_pc, 32'h200);
        rd(12'h341); check("plan_trap_mepc", obs_rdata, 32'h40);
        rd(12'h342); check("plan_trap_mcause", obs_rdata, 32'h8000_000B);
        rd(12'h300); check("plan_trap_mstatus", obs_rdata, 32'h80);

        cyc(1'b0, 1'b1, 32'h44, 12'h000, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("plan_mret_pc", obs_pc, 32'h40);
        rd(12'h300); check("plan_mret_mstatus", obs_rdata, 32'h88);

        cyc(1'b0, 1'b0, 32'h0, 12'h300, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 32'h80, 12'h300, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        check("plan_trap_vs_write", obs_pc, 32'h200);
        rd(12'h342); check("plan_timer_mcause", obs_rdata, 32'h8000_0007);
        rd(12'h300); check("plan_write_dropped", obs_rdata, 32'h80);

`ifdef CSR_COUNTERS_EN
        csrw(12'hB00, 2'b01, 32'hFFFF_FFFE);
        csrw(12'hB80, 2'b01, 32'h0);
        rd(12'hB00);
        rd(12'hB00); check("plan_mcycle_lo", obs_rdata, 32'h0);
        rd(12'hB80); check("plan_mcycle_hi", obs_rdata, 32'h1);
        csrw(12'hB02, 2'b01, 32'h0);
        csrw(12'hB82, 2'b01, 32'h0);
        ret_req = 1'b1;
        rd(12'h000); rd(12'h000); rd(12'h000);
        ret_req = 1'b0;
        rd(12'hB02); check("plan_minstret", obs_rdata, 32'h3);
`endif

        for (int i = 0; i < 400; i++) begin
            r_r  = ($urandom_range(0, 49) == 0);
            r_v  = ($urandom_range(0, 3) != 0);
            r_pc = $urandom & ~32'h3;
            r_a  = addrs[$urandom_range(0, 12)];
            r_wd = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            r_op = 2'($urandom_range(0, 3));
            r_we = ($urandom_range(0, 1) == 1);
            r_mr = !r_we && ($urandom_range(0, 5) == 0);
            r_ti = ($urandom_range(0, 3) == 0);
            r_ei = ($urandom_range(0, 5) == 0);
`ifdef CSR_COUNTERS_EN
            ret_req = ($urandom_range(0, 1) == 1);
`endif
            cyc(r_r, r_v, r_pc, r_a, r_wd, r_op, r_we, r_mr, r_ti, r_ei);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file and interrupt controller for the 3-stage RV32 pipeline.
- Sits directly upstream of the writeback select mux and drives its CSR input (select code 2'b11) with the CSR read value.
- Executes CSRRW/CSRRS/CSRRC, takes timer and external interrupts, and handles MRET.
- Supplies the fetch-stage redirect target on trap entry and on MRET.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0.
- HART_ID, 32'h0000_0000, read-only value of mhartid (0xF14).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  the execute stage holds a valid instruction this cycle
- pc_in  input  32  PC of the execute-stage instruction
- csr_addr  input  12  CSR address, inst[31:20]
- csr_wdata  input  32  rs1 value or zero-extended zimm, already resolved upstream
- csr_op  input  2  funct3[1:0]: 01 write, 10 set, 11 clear, 00 none
- csr_wr_en  input  1  instruction is a CSR instruction
- is_mret  input  1  instruction is MRET
- timer_irq  input  1  timer interrupt level
- ext_irq  input  1  external interrupt level
- csr_rdata  output  32  old CSR value, sent to the writeback mux
- redirect  output  1  flush the pipeline and load redirect_pc
- redirect_pc  output  32  trap vector or mepc

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit 3, MPIE bit 7; all other bits read 0.
  - mie 0x304: MTIE bit 7, MEIE bit 11.
  - mip 0x344: read-only; MTIP bit 7, MEIP bit 11.
  - mtvec 0x305, mepc 0x341, mcause 0x342, mhartid 0xF14 (read-only).
- Reset values: every CSR is 0 except mtvec = RESET_MTVEC. csr_rdata = 0 and redirect = 0 while rst is high.
- csr_rdata:
  - Combinational from csr_addr; shows the value before any write in the same cycle.
  - Unimplemented addresses read 0. Writes to them and to read-only CSRs are ignored.
- CSR write: occurs at the clock edge when instr_valid & csr_wr_en & no trap this cycle.
  - op 01: new = wdata.
  - op 10: new = old | wdata.
  - op 11: new = old & ~wdata.
  - Set/clear with wdata = 0 leaves the register unchanged.
  - Only implemented bits are stored. mepc[1:0] and mtvec[1:0] are forced to 0.
- mip sampling: mip bits are registered copies of timer_irq/ext_irq, giving one cycle of latency from pin to mip.
- Interrupt pending: irq = mstatus.MIE & ((MEIE & MEIP) | (MTIE & MTIP)).
- Trap entry: occurs when irq & instr_valid.
  - Same cycle, combinational: redirect = 1, redirect_pc = mtvec.
  - At the clock edge:
    - mepc <= pc_in (the interrupted instruction has not retired).
    - mcause <= 32'h8000_000B if external, else 32'h8000_0007. External has priority over timer.
    - MPIE <= MIE, MIE <= 0.
  - The CSR write of the same instruction is suppressed.
- MRET: occurs when instr_valid & is_mret & no trap.
  - Same cycle: redirect = 1, redirect_pc = mepc.
  - At the clock edge: MIE <= MPIE, MPIE <= 1.
- Simultaneous events:
  - Trap beats MRET; mepc receives the MRET's PC.
  - Trap beats a CSR write.
  - A CSR write that sets mstatus.MIE takes effect from the next cycle.
- redirect is 0 whenever instr_valid = 0.
- Reset mid-trap: every register returns to its reset value on the next edge. No partial update.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - Adds 64-bit mcycle (0xB00 low / 0xB80 high) and minstret (0xB02 / 0xB82), plus input instr_retired (1 bit).
  - mcycle increments every cycle not in reset.
  - minstret increments when instr_retired = 1.
  - Each counter wraps from all-ones to 0.
  - A CSR write to a counter half takes priority over the increment in that cycle; the other half is unaffected.
  - Reads return the pre-increment value.
- Undefined: those addresses read 0, writes are ignored, and no instr_retired port exists.

Test Plan:
- Reset, then read 0x305 with RESET_MTVEC = 32'h100 -> csr_rdata = 32'h100. Read 0x300 -> 0. Read 0x7C0 -> 0.
- CSRRW 0x341 wdata 32'h1237 -> csr_rdata = 0 that cycle; next read = 32'h1234.
- CSRRS 0x304 wdata 32'h880, then CSRRC wdata 32'h80 -> reads give 32'h880 then 32'h800.
- Interrupt entry:
  - Setup: mtvec = 32'h200, MIE = 1, MEIE = 1, MTIE = 1.
  - Stimulus: assert ext_irq and timer_irq together, with instr_valid = 1 and pc_in = 32'h40.
  - Response one cycle later: redirect = 1, redirect_pc = 32'h200.
  - After the edge: mepc = 32'h40, mcause = 32'h8000_000B, MIE = 0, MPIE = 1.
- MRET after the above -> redirect_pc = 32'h40; next cycle MIE = 1, MPIE = 1.
- CSRRW 0x300 in the same cycle as a pending trap -> write dropped; mcause updated.
- With CSR_COUNTERS_EN:
  - Write mcycle low = 32'hFFFF_FFFE, high = 0 -> after 2 cycles reads low = 0, high = 1.
  - Pulse instr_retired 3 times -> minstret = 3.
